multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the shared RV32I multicycle datapath: PC, instruction register, unified memory port, register file, ALU and immediate generator.
- Each instruction takes 3-5 states: fetch, decode, then an execute chain chosen by opcode.
- The block drives all mux selects and enables, including the immediate-format select for the immediate generator.
- A ready/request handshake stalls the sequence on memory access.

Parameters:
- OPCODE_W, 7, opcode field width.
- IMM_SRC_W, 3, immediate-format select width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  7  IR[6:0].
- funct3  input  3  IR[14:12]; used for branch sense.
- zero  input  1  ALU zero flag, valid in S_BRANCH.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory access active.
- mem_write  output  1  write strobe.
- adr_src  output  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  IR load enable.
- pc_write  output  1  PC load enable.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = zero, 11 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4.
- alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = funct decode.
- result_src  output  2  result select: 00 = ALUOut, 01 = MDR, 10 = ALU result.
- imm_src  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- illegal_instr  output  1  unknown opcode flag.

Behaviour:
- Reset:
  - rst is asynchronous and active-high; it forces state to S_FETCH.
  - All outputs then take their S_FETCH values: mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write and pc_write equal mem_ready. All other enables are 0, and illegal_instr = 0.
- Output timing:
  - Outputs decode from the state register only (Moore), plus the mem_ready/zero gating listed below.
  - Any output not listed for a state is 0.
- imm_src is combinational from opcode, independent of state:
  - lw / I-ALU → 000
  - sw → 001
  - beq/bne → 010
  - jal → 011
  - lui → 100
  - anything else → 000
- Opcodes decoded: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111, lui 0110111.
- States and transitions:
  - S_FETCH: mem_req; IR and PC+4 loaded when mem_ready. Stays while !mem_ready; → S_DECODE when mem_ready.
  - S_DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (computes branch/jump target). Next state by opcode:
    - lw/sw → S_MEMADR
    - R → S_EXECR
    - I-ALU → S_EXECI
    - branch → S_BRANCH
    - jal → S_JAL
    - lui → S_LUI
    - otherwise illegal_instr = 1 for this cycle, → S_FETCH.
  - S_MEMADR: alu_src_a = 11, alu_src_b = 01. → S_MEMREAD (lw) or S_MEMWRITE (sw).
  - S_MEMREAD: mem_req, adr_src = 1. Waits for mem_ready, then → S_MEMWB.
  - S_MEMWB: result_src = 01, reg_write. → S_FETCH.
  - S_MEMWRITE: mem_req, mem_write, adr_src = 1. Waits for mem_ready, then → S_FETCH.
  - S_EXECR: alu_src_a = 11, alu_src_b = 00, alu_op = 10. → S_ALUWB.
  - S_EXECI: alu_src_a = 11, alu_src_b = 01, alu_op = 10. → S_ALUWB.
  - S_ALUWB: result_src = 00, reg_write. → S_FETCH.
  - S_BRANCH:
    - Drives alu_src_a = 11, alu_src_b = 00, alu_op = 01, result_src = 00.
    - pc_write = (funct3 == 000 & zero) | (funct3 == 001 & !zero); other funct3 → no PC update.
    - → S_FETCH.
  - S_JAL: alu_src_a = 01, alu_src_b = 10, result_src = 00, pc_write. → S_ALUWB (writes rd = oldPC + 4).
  - S_LUI: alu_src_a = 10, alu_src_b = 01, alu_op = 00. → S_ALUWB.
- Latency with zero wait states:
  - 5 cycles: lw.
  - 4 cycles: sw, R, I-ALU, jal, lui.
  - 3 cycles: branch.
  - 2 cycles: illegal opcode.
  - Each memory stall cycle adds 1.
- Handshake rule: mem_req stays high and addresses stay stable until the cycle mem_ready = 1. mem_ready outside a requesting state is ignored.
- Reset mid-operation: the state is abandoned immediately and no write enables are asserted afterward. A pending mem_write is dropped in the same cycle rst rises.
- Unused state encodings recover to S_FETCH on the next clock.

Decomposition:
- Package mcu_pkg holds:
  - 4-bit state localparams S_FETCH..S_LUI (0..11).
  - Opcode constants.
  - IMM_* format codes.
  - ALU_SRC_A/B, ALU_OP and RESULT_SRC select codes.
- One sub-module: imm_src_decoder (combinational opcode → imm_src). It is reusable by a future pipelined control path.

Test Plan:
- Reset with mem_ready = 0: hold rst 3 cycles then release → state S_FETCH, mem_req = 1, ir_write = 0, pc_write = 0, reg_write = 0; asserting mem_ready → ir_write = pc_write = 1 for exactly that cycle.
- lw (0000011) with mem_ready low 2 cycles in each of S_FETCH and S_MEMREAD → imm_src = 000, one reg_write pulse with result_src = 01, total 9 cycles, returns to S_FETCH.
- sw (0100011), zero wait → imm_src = 001, mem_write = 1 with adr_src = 1 for one cycle, reg_write never asserted, 4 cycles.
- Branch opcode 1100011:
  - funct3 = 000, zero = 1 → pc_write in S_BRANCH.
  - funct3 = 000, zero = 0 → no pc_write.
  - funct3 = 001, zero = 0 → pc_write.
- Opcode 1111111 → illegal_instr = 1 for exactly 1 cycle (S_DECODE), next S_FETCH, no reg_write/mem_write.
- sw stalled in S_MEMWRITE (mem_ready = 0), assert rst → mem_write falls asynchronously the same cycle; after release the FSM restarts cleanly from S_FETCH with a jal (1101111) sequence giving pc_write in S_JAL then reg_write.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// mcu_pkg: shared definitions for the RV32I multicycle control path.
// Holds the FSM state encoding, decoded opcode constants, immediate-format
// codes and the mux-select codes driven onto the datapath.
package mcu_pkg;

    localparam int OPCODE_W  = 7;
    localparam int IMM_SRC_W = 3;

    // Encodings 12..15 are unused and fall back to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
    localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_SRC_A_ZERO  = 2'b10;
    localparam logic [1:0] ALU_SRC_A_RS1   = 2'b11;

    localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_SRC_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_SRC_MDR    = 2'b01;
    localparam logic [1:0] RESULT_SRC_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control <-> datapath signal bundle.
//   master: control unit (consumes instruction fields, flags, mem_ready;
//           drives memory handshake, enables, mux selects, imm_src).
//   slave : datapath/memory side (the mirror image).
interface multicycle_control_unit_if #(
    parameter int OPCODE_W  = 7,
    parameter int IMM_SRC_W = 3
);
    logic [OPCODE_W-1:0]  opcode;
    logic [2:0]           funct3;
    logic                 zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_write;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic [1:0]           result_src;
    logic [IMM_SRC_W-1:0] imm_src;
    logic                 illegal_instr;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_instr
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_unit_imm_src_decoder.sv
// imm_src_decoder: purely combinational opcode -> immediate-format select.
//   opcode  : instruction bits [6:0]
//   imm_src : I/S/B/J/U format code for the immediate generator
module imm_src_decoder
    import mcu_pkg::*;
#(
    parameter int OPCODE_W  = 7,
    parameter int IMM_SRC_W = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [IMM_SRC_W-1:0] imm_src
);
    always_comb begin
        unique case (opcode)
            OP_SW:     imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            OP_LUI:    imm_src = IMM_U;
            default:   imm_src = IMM_I;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the RV32I multicycle datapath.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (returns to S_FETCH)
//   bus : master side of multicycle_control_unit_if (instruction fields,
//         flags and mem_ready in; handshake, enables and selects out)
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W  = 7,
    parameter int IMM_SRC_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    multicycle_control_unit_if.master     bus
);
    state_t state, state_next;

    imm_src_decoder #(.OPCODE_W(OPCODE_W), .IMM_SRC_W(IMM_SRC_W)) u_imm_dec (
        .opcode  (bus.opcode),
        .imm_src (bus.imm_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I_ALU:     state_next = S_EXECI;
                    OP_BRANCH:    state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    OP_LUI:       state_next = S_LUI;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.adr_src       = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = ALU_SRC_A_PC;
        bus.alu_src_b     = ALU_SRC_B_RS2;
        bus.alu_op        = ALU_OP_ADD;
        bus.result_src    = RESULT_SRC_ALUOUT;
        bus.illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                bus.alu_src_b  = ALU_SRC_B_FOUR;
                bus.result_src = RESULT_SRC_ALU;
            end
            S_DECODE: begin
                bus.alu_src_a = ALU_SRC_A_OLDPC;
                bus.alu_src_b = ALU_SRC_B_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_R, OP_I_ALU, OP_BRANCH, OP_JAL, OP_LUI: ;
                    default: bus.illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = ALU_SRC_A_RS1;
                bus.alu_src_b = ALU_SRC_B_IMM;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src = RESULT_SRC_MDR;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = ALU_SRC_A_RS1;
                bus.alu_src_b = ALU_SRC_B_RS2;
                bus.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                bus.alu_src_a = ALU_SRC_A_RS1;
                bus.alu_src_b = ALU_SRC_B_IMM;
                bus.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = ALU_SRC_A_RS1;
                bus.alu_src_b = ALU_SRC_B_RS2;
                bus.alu_op    = ALU_OP_SUB;
                // beq takes on zero, bne on !zero; other funct3 never redirect
                bus.pc_write  = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                                ((bus.funct3 == 3'b001) && !bus.zero);
            end
            S_JAL: begin
                bus.alu_src_a = ALU_SRC_A_OLDPC;
                bus.alu_src_b = ALU_SRC_B_FOUR;
                bus.pc_write  = 1'b1;
            end
            S_LUI: begin
                bus.alu_src_a = ALU_SRC_A_ZERO;
                bus.alu_src_b = ALU_SRC_B_IMM;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Output vector order: mem_req, mem_write, adr_src, ir_write, pc_write,
// reg_write, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], result_src[1:0],
// illegal_instr.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OPCODE_W(7), .IMM_SRC_W(3)) bus ();

    multicycle_control_unit #(.OPCODE_W(7), .IMM_SRC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [14:0] V_F0   = 15'b100000_00_10_00_10_0;
    localparam logic [14:0] V_F1   = 15'b100110_00_10_00_10_0;
    localparam logic [14:0] V_DEC  = 15'b000000_01_01_00_00_0;
    localparam logic [14:0] V_DECI = 15'b000000_01_01_00_00_1;
    localparam logic [14:0] V_MADR = 15'b000000_11_01_00_00_0;
    localparam logic [14:0] V_MRD  = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] V_MWB  = 15'b000001_00_00_00_01_0;
    localparam logic [14:0] V_MWR  = 15'b111000_00_00_00_00_0;
    localparam logic [14:0] V_EXR  = 15'b000000_11_00_10_00_0;
    localparam logic [14:0] V_EXI  = 15'b000000_11_01_10_00_0;
    localparam logic [14:0] V_AWB  = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] V_BRN  = 15'b000000_11_00_01_00_0;
    localparam logic [14:0] V_BRT  = 15'b000010_11_00_01_00_0;
    localparam logic [14:0] V_JAL  = 15'b000010_01_10_00_00_0;
    localparam logic [14:0] V_LUI  = 15'b000000_10_01_00_00_0;

    function automatic logic [14:0] outs();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.result_src, bus.illegal_instr};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 7'b0010011;
        bus.funct3 = 3'b000;
        bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (outs() !== V_F0) $display("FAIL reset_held actual=%b required=%b", outs(), V_F0);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (outs() !== V_F0) $display("FAIL reset_release actual=%b required=%b", outs(), V_F0);
        else passed++;
        begin
            logic [14:0] ev[$] = '{V_F1, V_DEC, V_EXI, V_AWB, V_F0};
            logic        rv[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            foreach (ev[i]) begin
                if (i > 0) @(negedge clk);
                bus.mem_ready = rv[i];
                #1;
                total++;
                if (outs() !== ev[i]) $display("FAIL reset_first_fetch[%0d] actual=%b required=%b", i, outs(), ev[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_lw_stalled();
        logic [14:0] ev[$] = '{V_F0, V_F0, V_F1, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MWB, V_F0};
        logic        rv[$] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.opcode = 7'b0000011;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = rv[i];
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL lw_stall[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        total++;
        if (bus.imm_src !== 3'b000) $display("FAIL lw_imm_src actual=%b required=000", bus.imm_src);
        else passed++;
    endtask

    task automatic test_sw();
        logic [14:0] ev[$] = '{V_F1, V_DEC, V_MADR, V_MWR, V_F0};
        logic        rv[$] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.opcode = 7'b0100011;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = rv[i];
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL sw[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        total++;
        if (bus.imm_src !== 3'b001) $display("FAIL sw_imm_src actual=%b required=001", bus.imm_src);
        else passed++;
    endtask

    // mem_ready held high everywhere: must be ignored outside S_FETCH
    task automatic test_r_type();
        logic [14:0] ev[$] = '{V_F1, V_DEC, V_EXR, V_AWB};
        bus.opcode = 7'b0110011;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL r_type[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if (outs() !== V_F0) $display("FAIL r_type_return actual=%b required=%b", outs(), V_F0);
        else passed++;
    endtask

    task automatic test_lui();
        logic [14:0] ev[$] = '{V_F1, V_DEC, V_LUI, V_AWB, V_F0};
        logic        rv[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.opcode = 7'b0110111;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = rv[i];
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL lui[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        total++;
        if (bus.imm_src !== 3'b100) $display("FAIL lui_imm_src actual=%b required=100", bus.imm_src);
        else passed++;
    endtask

    task automatic test_branch();
        logic [2:0]  f3[3]  = '{3'b000, 3'b000, 3'b001};
        logic        zr[3]  = '{1'b1, 1'b0, 1'b0};
        logic [14:0] brv[3] = '{V_BRT, V_BRN, V_BRT};
        bus.opcode = 7'b1100011;
        for (int k = 0; k < 3; k++) begin
            logic [14:0] ev[$] = '{V_F1, V_DEC, brv[k], V_F0};
            logic        rv[$] = '{1'b1, 1'b0, 1'b0, 1'b0};
            bus.funct3 = f3[k];
            bus.zero = zr[k];
            foreach (ev[i]) begin
                @(negedge clk);
                bus.mem_ready = rv[i];
                #1;
                total++;
                if (outs() !== ev[i]) $display("FAIL branch%0d[%0d] actual=%b required=%b", k, i, outs(), ev[i]);
                else passed++;
            end
        end
        total++;
        if (bus.imm_src !== 3'b010) $display("FAIL branch_imm_src actual=%b required=010", bus.imm_src);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [14:0] ev[$] = '{V_F1, V_DECI, V_F0};
        logic        rv[$] = '{1'b1, 1'b0, 1'b0};
        bus.opcode = 7'b1111111;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = rv[i];
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL illegal[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        total++;
        if (bus.imm_src !== 3'b000) $display("FAIL illegal_imm_src actual=%b required=000", bus.imm_src);
        else passed++;
    endtask

    task automatic test_reset_mid_store();
        logic [14:0] ev[$] = '{V_F1, V_DEC, V_MADR, V_MWR, V_MWR};
        logic        rv[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.opcode = 7'b0100011;
        foreach (ev[i]) begin
            @(negedge clk);
            bus.mem_ready = rv[i];
            #1;
            total++;
            if (outs() !== ev[i]) $display("FAIL sw_stall[%0d] actual=%b required=%b", i, outs(), ev[i]);
            else passed++;
        end
        // Reset rises mid-cycle, well away from any clock edge
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0) $display("FAIL async_drop_mem_write actual=%b required=0", bus.mem_write);
        else passed++;
        total++;
        if (outs() !== V_F0) $display("FAIL async_reset_outs actual=%b required=%b", outs(), V_F0);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.opcode = 7'b1101111;
        begin
            logic [14:0] jv[$] = '{V_F0, V_F1, V_DEC, V_JAL, V_AWB, V_F0};
            logic        jr[$] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            foreach (jv[i]) begin
                if (i > 0) @(negedge clk);
                bus.mem_ready = jr[i];
                #1;
                total++;
                if (outs() !== jv[i]) $display("FAIL jal_after_reset[%0d] actual=%b required=%b", i, outs(), jv[i]);
                else passed++;
            end
        end
        total++;
        if (bus.imm_src !== 3'b011) $display("FAIL jal_imm_src actual=%b required=011", bus.imm_src);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lw_stalled();
        test_sw();
        test_r_type();
        test_lui();
        test_branch();
        test_illegal();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
